// File: rtl/rate_divider_bank_pkg.sv
// Shared constants for the rate divider bank: output modes, default width, channel-index width.
// No logic, no latency.
// No flow control.
package rate_div_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    localparam int DEF_WIDTH = 26;

    // An index bus is never narrower than one bit, even for a single channel.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rate_divider_bank_channel.sv
// One divider channel: down-counter, divisor/mode registers, registered tick/square output.
// Latency: a terminal count shows on clock_out one cycle later; a write applies on the next edge.
// Backpressure: with RATE_DIV_SHADOW_EN a retune of a running channel waits in a shadow until its terminal.
module rate_divider_channel
    import rate_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock_in,
    input  logic             clear,
    input  logic             active,
    input  logic             wr_stb,
    input  logic [WIDTH-1:0] wr_divisor,
    input  logic             wr_mode,
    output logic             clock_out,
    output logic             pending
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] nxt_cnt;
    logic             mode;
    logic             live;
    logic             term;
    logic             nxt_out;

    assign live = active && (div != '0);
    assign term = live && (cnt == '0);

    function automatic logic [WIDTH-1:0] first_cnt(input logic [WIDTH-1:0] d);
        return (d == '0) ? '0 : d - ONE;
    endfunction

    always_comb begin
        nxt_cnt = cnt;
        nxt_out = (mode == MODE_SQUARE) ? clock_out : 1'b0;
        if (term) begin
            nxt_cnt = div - ONE;
            nxt_out = (mode == MODE_SQUARE) ? ~clock_out : 1'b1;
        end else if (live) begin
            nxt_cnt = cnt - ONE;
        end
    end

`ifdef RATE_DIV_SHADOW_EN
    logic [WIDTH-1:0] sh_div;
    logic             sh_mode;

    always_ff @(posedge clock_in or posedge clear) begin
        if (clear) begin
            div       <= '0;
            cnt       <= '0;
            mode      <= MODE_PULSE;
            clock_out <= 1'b0;
            sh_div    <= '0;
            sh_mode   <= MODE_PULSE;
            pending   <= 1'b0;
        end else if (wr_stb && !live) begin
            div       <= wr_divisor;
            mode      <= wr_mode;
            cnt       <= first_cnt(wr_divisor);
            clock_out <= 1'b0;
        end else if (pending && !live) begin
            div       <= sh_div;
            mode      <= sh_mode;
            cnt       <= first_cnt(sh_div);
            clock_out <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (wr_stb) begin
                sh_div  <= wr_divisor;
                sh_mode <= wr_mode;
                pending <= 1'b1;
            end
            // The closing terminal still ticks with the old setting; the new period starts right after it.
            if (term && pending) begin
                div       <= sh_div;
                mode      <= sh_mode;
                cnt       <= first_cnt(sh_div);
                clock_out <= (sh_div == '0) ? 1'b0 : nxt_out;
                pending   <= 1'b0;
            end else begin
                cnt       <= nxt_cnt;
                clock_out <= nxt_out;
            end
        end
    end
`else
    assign pending = 1'b0;

    always_ff @(posedge clock_in or posedge clear) begin
        if (clear) begin
            div       <= '0;
            cnt       <= '0;
            mode      <= MODE_PULSE;
            clock_out <= 1'b0;
        end else if (wr_stb) begin
            div       <= wr_divisor;
            mode      <= wr_mode;
            cnt       <= first_cnt(wr_divisor);
            clock_out <= 1'b0;
        end else begin
            cnt       <= nxt_cnt;
            clock_out <= nxt_out;
        end
    end
`endif

endmodule

// File: rtl/rate_divider_bank.sv
// Multi-channel rate divider: per-channel enable ticks or 50% squares at clock_in/D (shadow retune: RATE_DIV_SHADOW_EN).
// Latency: outputs registered, one cycle after each terminal count; writes land on the next edge.
// Backpressure: wr_ready drops while the addressed channel holds a pending shadow write.
module rate_divider_bank
    import rate_div_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                        clock_in,
    input  logic                        clear,
    input  logic                        enable,
    input  logic [CHANNELS-1:0]         ch_enable,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [chan_w(CHANNELS)-1:0] wr_chan,
    input  logic [WIDTH-1:0]            wr_divisor,
    input  logic                        wr_mode,
    output logic [CHANNELS-1:0]         clock_out,
    output logic [CHANNELS-1:0]         pending
);

    localparam int CW = chan_w(CHANNELS);

    logic wr_acc;

`ifdef RATE_DIV_SHADOW_EN
    // Padding to the full index range makes out-of-range channels read as never pending.
    logic [2**CW-1:0] pend_pad;
    assign pend_pad = (2**CW)'(pending);
    assign wr_ready = ~pend_pad[wr_chan];
`else
    assign wr_ready = 1'b1;
`endif

    assign wr_acc = wr_valid && wr_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        rate_divider_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clock_in  (clock_in),
            .clear     (clear),
            .active    (enable && ch_enable[i]),
            .wr_stb    (wr_acc && (wr_chan == CW'(i))),
            .wr_divisor(wr_divisor),
            .wr_mode   (wr_mode),
            .clock_out (clock_out[i]),
            .pending   (pending[i])
        );
    end

endmodule

// File: tb/tb_rate_divider_bank.sv
// Directed bench for rate_divider_bank (3 channels, 4-bit divisors); expectations follow RATE_DIV_SHADOW_EN.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_rate_divider_bank;

`ifdef RATE_DIV_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clock_in;
    logic       clear;
    logic       enable;
    logic [2:0] ch_enable;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_chan;
    logic [3:0] wr_divisor;
    logic       wr_mode;
    logic [2:0] clock_out;
    logic [2:0] pending;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] hist [0:63];

    rate_divider_bank #(
        .CHANNELS(3),
        .WIDTH   (4)
    ) dut (
        .clock_in  (clock_in),
        .clear     (clear),
        .enable    (enable),
        .ch_enable (ch_enable),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_chan   (wr_chan),
        .wr_divisor(wr_divisor),
        .wr_mode   (wr_mode),
        .clock_out (clock_out),
        .pending   (pending)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic sample(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            hist[k] = clock_out;
        end
    endtask

    function automatic logic [63:0] bits(input int ch, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = hist[k][ch];
        return v;
    endfunction

    task automatic wr(input int ch, input int d, input logic m);
        int n;
        n = 0;
        wr_valid   = 1'b1;
        wr_chan    = 2'(ch);
        wr_divisor = 4'(d);
        wr_mode    = m;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        chk("wr_accept", 64'(wr_ready), 64'h1);
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear      = 1'b0;
        enable     = 1'b1;
        ch_enable  = 3'b111;
        wr_valid   = 1'b0;
        wr_chan    = 2'd0;
        wr_divisor = 4'd0;
        wr_mode    = 1'b0;

        #1 clear = 1'b1;
        #1;
        chk("rst_clock_out", 64'(clock_out), 64'h0);
        chk("rst_pending",   64'(pending),   64'h0);
        chk("rst_wr_ready",  64'(wr_ready),  64'h1);
        tick();
        tick();
        clear = 1'b0;

        // Pulse mode, D=5 on ch0.
        wr(0, 5, 1'b0);
        sample(15);
        chk("pulse_ch0",   bits(0, 15), 64'h4210);
        chk("pulse_ch1_0", bits(1, 15), 64'h0);
        chk("pulse_ch2_0", bits(2, 15), 64'h0);

        // Square mode, D=3 on ch1.
        wr(1, 3, 1'b1);
        sample(12);
        chk("square_ch1", bits(1, 12), 64'h71C);

        // Retune ch2 from D=4 to D=2 mid-period.
        wr(2, 4, 1'b0);
        sample(6);
        chk("retune_pre", bits(2, 6), 64'h08);
        wr(2, 2, 1'b0);
        chk("retune_pending",  64'(pending[2]), SHADOW ? 64'h1 : 64'h0);
        chk("retune_wr_ready", 64'(wr_ready),   SHADOW ? 64'h0 : 64'h1);
        sample(6);
        chk("retune_post", bits(2, 6), SHADOW ? 64'h15 : 64'h2A);
        chk("retune_pending_clr", 64'(pending), 64'h0);

        // Global enable stall on ch0 at D=4.
        ch_enable = 3'b110;
        wr(0, 4, 1'b0);
        ch_enable = 3'b111;
        sample(2);
        chk("stall_pre", bits(0, 2), 64'h0);
        enable = 1'b0;
        sample(7);
        chk("stall_ch0",     bits(0, 7), 64'h0);
        chk("stall_ch2_low", bits(2, 7), 64'h0);
        enable = 1'b1;
        sample(8);
        chk("stall_resume", bits(0, 8), 64'h22);

        // Out-of-range channel write is accepted and changes nothing.
        wr(3, 1, 1'b0);
        sample(4);
        chk("oor_ch0",     bits(0, 4), 64'h1);
        chk("oor_pending", 64'(pending), 64'h0);

        // D=0 disables the channel.
        ch_enable = 3'b110;
        wr(0, 0, 1'b0);
        ch_enable = 3'b111;
        sample(10);
        chk("d0_ch0",     bits(0, 10), 64'h0);
        chk("d0_pending", 64'(pending), 64'h0);

        // Maximum divisor 15 on a 4-bit build: no early wrap.
        ch_enable = 3'b101;
        wr(1, 15, 1'b0);
        ch_enable = 3'b111;
        sample(31);
        chk("dmax_ch1", bits(1, 31), 64'h2000_4000);

        // D=1 everywhere, then asynchronous clear between edges.
        ch_enable = 3'b000;
        wr(0, 1, 1'b0);
        wr(1, 1, 1'b0);
        wr(2, 1, 1'b0);
        ch_enable = 3'b111;
        sample(3);
        chk("d1_ch0", bits(0, 3), 64'h7);
        chk("d1_ch1", bits(1, 3), 64'h7);
        chk("d1_ch2", bits(2, 3), 64'h7);
        wr(2, 1, 1'b1);
        chk("pre_clear_pending", 64'(pending), SHADOW ? 64'h4 : 64'h0);
        #2 clear = 1'b1;
        #1;
        chk("clear_clock_out", 64'(clock_out), 64'h0);
        chk("clear_pending",   64'(pending),   64'h0);
        #2 clear = 1'b0;
        chk("clear_wr_ready",  64'(wr_ready),  64'h1);
        sample(5);
        chk("post_clear_ch0", bits(0, 5), 64'h0);
        chk("post_clear_ch1", bits(1, 5), 64'h0);
        chk("post_clear_ch2", bits(2, 5), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_divider_bank.md
# rate_divider_bank

Parametrised multi-channel rate divider: `CHANNELS` independent down-counters, each producing either a one-cycle enable tick or a 50 % square wave at `clock_in / D`. Divisors and modes are written at run time through a valid/ready port. This is the next generation of the single-channel divider. It feeds clock-enable strobes to timers, LED blinkers and baud generators elsewhere in the design. All outputs are synchronous to `clock_in`; nothing here is a generated clock.

## Interface
- `CHANNELS`, 4: number of independent channels (1–16).
- `WIDTH`, 26: counter/divisor width in bits.
- `clock_in` in 1: sole clock, rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `enable` in 1: global count enable.
- `ch_enable` in `CHANNELS`: per-channel count enable.
- `wr_valid` in 1: divisor write request.
- `wr_ready` out 1: write can be accepted this cycle.
- `wr_chan` in `max(1,$clog2(CHANNELS))`: target channel; values ≥ `CHANNELS` are accepted and dropped.
- `wr_divisor` in `WIDTH`: new divisor D.
- `wr_mode` in 1: 0 = pulse, 1 = square.
- `clock_out` out `CHANNELS`: per-channel tick or square output.
- `pending` out `CHANNELS`: shadow write waiting to apply.

## Operation
- Each channel holds `div`, `mode`, and counter `cnt`.
- A channel is active when `enable & ch_enable[i] & (div != 0)`.
- An active channel with `cnt == 0` is at terminal. At terminal, `cnt` reloads to `div-1`; otherwise `cnt` decrements. An inactive channel holds `cnt`.
- D = 0: the channel is disabled. `cnt` is held at 0 and `clock_out[i]` is forced to 0.
- Pulse mode: `clock_out[i]` is high for exactly one cycle after each terminal. D = 1 keeps it high continuously while the channel is active.
- Square mode: `clock_out[i]` toggles after each terminal, giving period 2·D active cycles with exact 50 % duty. It holds its level while the channel is inactive.
- Write accept: `wr_valid & wr_ready`.
- Applying a write means:
  - `div ← wr_divisor` and `mode ← wr_mode`;
  - `cnt ← wr_divisor-1` (0 if D = 0);
  - `clock_out[i] ← 0`.
- A write to an inactive channel applies on the next edge.
- Arithmetic: `div-1` is computed in `WIDTH` bits and is never evaluated with div = 0. Counters never wrap below 0.

## Timing
- Reset (async, immediate, no clock required) clears all of: `cnt`, `div`, `mode`, shadow registers, `clock_out`, `pending`. `wr_ready` is 1.
- Tick latency: `clock_out` is registered, so a terminal in cycle n makes `clock_out` high in cycle n+1.
- First tick after a write to an idle channel: the D-th active cycle after application is the terminal; `clock_out` rises one cycle later. Subsequent ticks are exactly D active cycles apart.
- `wr_ready` is combinational from `pending[wr_chan]` (the shadow-build state): low while the addressed channel has a pending write. `wr_valid` may be held until accepted; the write fields must stay stable while waiting.
- Simultaneous terminal and accept on the same channel: the current terminal uses the old divisor, and the new value goes pending.
- `clear` asserted mid-count aborts all channels and discards pending writes.

## Configuration
- `RATE_DIV_SHADOW_EN` defined:
  - A write to an active channel is stored in a per-channel shadow register and `pending[i]` rises the next cycle.
  - The shadow applies at that channel's next terminal, so the current period always completes (glitch-free retune), and `pending[i]` then clears.
  - If the channel goes inactive while pending, the shadow applies on the next edge.
- `RATE_DIV_SHADOW_EN` undefined:
  - Every write applies on the next edge, restarting the count.
  - `pending` is tied to 0 and `wr_ready` is tied to 1.
  - No shadow registers are built.

## Structure
- Package `rate_div_pkg` holds:
  - mode constants `MODE_PULSE = 0` and `MODE_SQUARE = 1`;
  - the default `WIDTH`;
  - the channel-index width function.
- Sub-module `rate_divider_channel` holds one channel: counter, div/mode registers, optional shadow, output register. Its ports are a write strobe, data, active and clear.
- The top level decodes `wr_chan`, muxes `pending` onto `wr_ready`, and generates the `CHANNELS` instances.

## Test plan
- Pulse: ch0, D=5, all enables high → `clock_out[0]` high 1 cycle in every 5; other channels stay 0.
- Square: ch1, D=3 → `clock_out[1]` runs 3 high / 3 low, period 6, starting low after the write.
- Shadow (macro on): ch2 at D=4, write D=2 mid-period → `pending[2]`=1 and `wr_ready`=0 for `wr_chan`=2; the remaining 4-period completes, then ticks every 2 cycles and `pending` clears. With the macro off, ticks move to every 2 cycles immediately after the write.
- Stall: drop `enable` for 7 cycles mid-count → no ticks, counters frozen; the tick spacing resumes exactly where it stopped.
- Async `clear` between clock edges with D=1 on all channels → all `clock_out` and `pending` go to 0 before the next edge; afterwards all channels stay idle until rewritten.
- Edge values: D=0 write → output held 0. D=2^WIDTH−1 → no early wrap (use WIDTH=4 build: tick every 15 cycles). Out-of-range `wr_chan` → accepted, no channel changes.
